// File: rtl/ibex_l2rf_pkg.sv
// ibex_l2rf_pkg: FSM states and register count; IBEX_L2RF_RV32E_EN selects the RV32E register file
package ibex_l2rf_pkg;
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_e;
`ifdef IBEX_L2RF_RV32E_EN
  localparam int NUM_REGS = 15;
`else
  localparam int NUM_REGS = 31;
`endif
endpackage

// File: rtl/ibex_l2rf_out_slice.sv
// ibex_l2rf_out_slice: one-entry valid/ready register slice for the save stream
module ibex_l2rf_out_slice #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_addr,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_addr,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_last
);
  assign in_ready = !out_valid || out_ready;
  // Load a new beat whenever the slot is empty or being drained; last clears when the slot empties
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_last  <= in_valid && in_last;
      if (in_valid) begin
        out_addr <= in_addr;
        out_data <= in_data;
      end
    end
  end
endmodule

// File: rtl/ibex_l2_rf_ctx_engine.sv
// ibex_l2_rf_ctx_engine: saves/restores the L2 register file over streams; IBEX_L2RF_RV32E_EN limits it to 15 registers
module ibex_l2_rf_ctx_engine
  import ibex_l2rf_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sv_valid_o,
  input  logic                 sv_ready_i,
  output logic [4:0]           sv_addr_o,
  output logic [DataWidth-1:0] sv_data_o,
  output logic                 sv_last_o,
  input  logic                 rs_valid_i,
  output logic                 rs_ready_o,
  input  logic [DataWidth-1:0] rs_data_i,
  output logic [4:0]           l2_addr_o,
  output logic [DataWidth-1:0] l2_wdata_o,
  output logic                 l2_we_o,
  input  logic [DataWidth-1:0] l2_rdata_i
);
  localparam logic [5:0] LastIdx = 6'(NUM_REGS);
  state_e     state, state_n;
  logic [5:0] idx, idx_n;
  logic       cap_valid, cap_ready, rs_fire;
  // The index runs one past the last register in SAVE so reading stops cleanly
  assign cap_valid  = state == SAVE && idx <= LastIdx;
  assign rs_fire    = state == RESTORE && rs_valid_i;
  assign busy_o     = state != IDLE;
  assign done_o     = state == DONE;
  assign rs_ready_o = state == RESTORE;
  assign l2_we_o    = rs_fire;
  assign l2_wdata_o = rs_fire ? rs_data_i : '0;
  assign l2_addr_o  = (state == SAVE || state == RESTORE) ? idx[4:0] : 5'd0;
  ibex_l2rf_out_slice #(.DataWidth(DataWidth)) u_slice (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (cap_valid),
    .in_ready  (cap_ready),
    .in_addr   (idx[4:0]),
    .in_data   (l2_rdata_i),
    .in_last   (idx == LastIdx),
    .out_valid (sv_valid_o),
    .out_ready (sv_ready_i),
    .out_addr  (sv_addr_o),
    .out_data  (sv_data_o),
    .out_last  (sv_last_o)
  );
  // State and index registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx   <= 6'd1;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end
  // Next state and index; save has priority over restore, requests while busy are dropped
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        idx_n   = 6'd1;
        state_n = save_req_i ? SAVE : restore_req_i ? RESTORE : IDLE;
      end
      SAVE: begin
        idx_n   = (cap_valid && cap_ready) ? idx + 6'd1 : idx;
        state_n = (sv_valid_o && sv_ready_i && sv_last_o) ? DONE : SAVE;
      end
      RESTORE: begin
        idx_n   = rs_fire ? idx + 6'd1 : idx;
        state_n = (rs_fire && idx == LastIdx) ? DONE : RESTORE;
      end
      default: begin
        idx_n   = 6'd1;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ibex_l2_rf_ctx_engine.sv
// tb_ibex_l2_rf_ctx_engine: randomized save/restore checks against a register-file reference model
module tb_ibex_l2_rf_ctx_engine;
`ifdef IBEX_L2RF_RV32E_EN
  localparam int N = 15;
`else
  localparam int N = 31;
`endif
  logic        clk = 0, rst = 1;
  logic        save_req = 0, restore_req = 0, sv_ready = 0, rs_valid = 0, load = 0;
  logic [31:0] rs_data = '0;
  logic        busy, done, sv_valid, sv_last, rs_ready, l2_we;
  logic [4:0]  sv_addr, l2_addr;
  logic [31:0] sv_data, l2_wdata, l2_rdata;
  logic [31:0] mem [32];
  logic [31:0] exp_mem [32];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign l2_rdata = mem[l2_addr];

  always @(posedge clk) begin
    if (load) mem <= exp_mem;
    else if (l2_we) mem[l2_addr] <= l2_wdata;
  end

  ibex_l2_rf_ctx_engine #(.DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .save_req_i(save_req), .restore_req_i(restore_req),
    .busy_o(busy), .done_o(done), .sv_valid_o(sv_valid), .sv_ready_i(sv_ready),
    .sv_addr_o(sv_addr), .sv_data_o(sv_data), .sv_last_o(sv_last),
    .rs_valid_i(rs_valid), .rs_ready_o(rs_ready), .rs_data_i(rs_data),
    .l2_addr_o(l2_addr), .l2_wdata_o(l2_wdata), .l2_we_o(l2_we), .l2_rdata_i(l2_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input bit rnd);
    for (int i = 0; i < 32; i++) exp_mem[i] = rnd ? $urandom : 32'hA000_0000 + 32'(i);
    @(negedge clk); load = 1;
    @(negedge clk); load = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sv_valid"}, 32'(sv_valid), 0);
    chk({tag, "_rs_ready"}, 32'(rs_ready), 0);
    chk({tag, "_we"}, 32'(l2_we), 0);
    chk({tag, "_l2_addr"}, 32'(l2_addr), 0);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1 with both requests and restore held during save; 2: random ready
  task automatic run_save(input int mode);
    int beat = 1, cyc = 0, done_cyc = -1;
    logic held = 0, pl = 0;
    logic [4:0] pa = '0;
    logic [31:0] pd = '0;
    @(negedge clk); save_req = 1; restore_req = (mode == 1);
    @(negedge clk); save_req = 0;
    chk("save_busy", 32'(busy), 1);
    chk("save_not_restore", 32'(rs_ready), 0);
    chk("save_first_valid", 32'(sv_valid), 0);
    while (done_cyc < 0 && cyc < 400) begin
      sv_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      if (held) begin
        chk("stall_valid", 32'(sv_valid), 1);
        chk("stall_addr", 32'(sv_addr), 32'(pa));
        chk("stall_data", sv_data, pd);
        chk("stall_last", 32'(sv_last), 32'(pl));
      end
      if (done) begin
        done_cyc = cyc;
        restore_req = 0;
      end else if (sv_valid && sv_ready) begin
        chk("beat_addr", 32'(sv_addr), 32'(beat));
        chk("beat_data", sv_data, exp_mem[beat]);
        chk("beat_last", 32'(sv_last), 32'(beat == N));
        beat++;
      end
      held = sv_valid && !sv_ready;
      pa = sv_addr; pd = sv_data; pl = sv_last;
      cyc++;
      @(negedge clk);
    end
    sv_ready = 0;
    chk("save_done_seen", 32'(done_cyc >= 0), 1);
    chk("save_beats", 32'(beat), 32'(N + 1));
    if (mode == 0) chk("save_latency", 32'(done_cyc), 32'(N + 1));
    check_idle_outputs("save_end");
  endtask

  // abort_at nonzero: stop (without ending) once that many beats were written
  task automatic run_restore(input int abort_at);
    int beat = 1, cyc = 0;
    logic v, done_seen = 0;
    @(negedge clk); restore_req = 1;
    @(negedge clk); restore_req = 0;
    chk("rs_busy", 32'(busy), 1);
    while (cyc < 600) begin
      if (abort_at != 0 && beat > abort_at) break;
      if (done) begin
        done_seen = 1;
        break;
      end
      chk("rs_ready", 32'(rs_ready), 1);
      v = $urandom_range(0, 2) != 0;
      rs_valid = v;
      rs_data = 32'h5A5A_0000 + 32'(beat);
      #1;
      chk("rs_we", 32'(l2_we), 32'(v));
      if (v) begin
        chk("rs_addr", 32'(l2_addr), 32'(beat));
        chk("rs_wdata", l2_wdata, rs_data);
        exp_mem[beat] = rs_data;
        beat++;
      end
      cyc++;
      @(negedge clk);
      rs_valid = 0;
    end
    if (abort_at == 0) begin
      chk("rs_done_seen", 32'(done_seen), 1);
      chk("rs_beats", 32'(beat), 32'(N + 1));
      @(negedge clk);
      check_idle_outputs("rs_end");
    end
  endtask

  task automatic compare_mem(input string tag, input int lo);
    for (int i = lo; i <= N; i++) chk(tag, mem[i], exp_mem[i]);
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    chk("reset_sv_addr", 32'(sv_addr), 0);
    chk("reset_sv_data", sv_data, 0);
    chk("reset_sv_last", 32'(sv_last), 0);
    chk("reset_wdata", l2_wdata, 0);
    load_mem(0);
    @(negedge clk); rst = 0;
    run_save(0);
    load_mem(1);
    run_save(1);
    chk("no_queued_restore", 32'(busy), 0);
    run_save(2);
    run_restore(0);
    compare_mem("restore_mem", 0);
    load_mem(1);
    run_restore(10);
    rst = 1;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    rst = 0;
    compare_mem("abort_mem", 0);
    run_restore(0);
    compare_mem("rerestore_mem", 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
